// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access width codes, FSM states
// and the wait-state limit.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MW_B  = 3'd0,
    MW_H  = 3'd1,
    MW_W  = 3'd2,
    MW_BU = 3'd4,
    MW_HU = 3'd5
  } mem_width_t;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dmem_state_t;

  localparam int DMEM_MAX_WAIT = 15;
  localparam int WAIT_CNT_W    = $clog2(DMEM_MAX_WAIT + 1);

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the RV32I core (master) and a data memory (slave):
// a valid/ready request channel and a valid/ready response channel.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: store byte enables and lane
// replication, load extraction with sign/zero extension, and access legality.
module dmem_lane_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rawWord,
  output logic [3:0]  byteEn,
  output logic [31:0] wdataShift,
  output logic [31:0] loadData,
  output logic        alignErr
);
  import dmem_responder_pkg::*;

  logic signed [7:0]  byteS;
  logic signed [15:0] halfS;

  always_comb begin
    byteS      = rawWord[{addrLo, 3'b000} +: 8];
    halfS      = rawWord[{addrLo[1], 4'b0000} +: 16];
    byteEn     = '0;
    wdataShift = '0;
    loadData   = '0;
    alignErr   = 1'b0;

    if (we) begin
      // Store data is replicated across lanes; byteEn picks the live ones.
      case (funct3)
        MW_B: begin
          byteEn     = 4'b0001 << addrLo;
          wdataShift = {4{wdata[7:0]}};
        end
        MW_H: begin
          if (addrLo[0]) begin
            alignErr = 1'b1;
          end else begin
            byteEn     = addrLo[1] ? 4'b1100 : 4'b0011;
            wdataShift = {2{wdata[15:0]}};
          end
        end
        MW_W: begin
          if (addrLo != 2'b00) begin
            alignErr = 1'b1;
          end else begin
            byteEn     = 4'b1111;
            wdataShift = wdata;
          end
        end
        default: alignErr = 1'b1;
      endcase
    end else begin
      case (funct3)
        MW_B:  loadData = 32'(byteS);
        MW_BU: loadData = {24'd0, byteS};
        MW_H: begin
          if (addrLo[0]) alignErr = 1'b1;
          else           loadData = 32'(halfS);
        end
        MW_HU: begin
          if (addrLo[0]) alignErr = 1'b1;
          else           loadData = {16'd0, halfS};
        end
        MW_W: begin
          if (addrLo != 2'b00) alignErr = 1'b1;
          else                 loadData = rawWord;
        end
        default: alignErr = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined RV32I core: one request at a time,
// WAIT_CYCLES wait states, byte-lane stores and extended loads with error flag.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  import dmem_responder_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit ZeroWait = (WAIT_CYCLES == 0);
  localparam logic [WAIT_CNT_W-1:0] WaitInit =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t           state;
  logic [WAIT_CNT_W-1:0] waitCnt;
  logic                  rspValid;
  logic [31:0]           rspRdata;
  logic                  rspErr;

  logic        weReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic [2:0]  funct3Reg;

  logic        effWe;
  logic [31:0] effAddr;
  logic [31:0] effWdata;
  logic [2:0]  effFunct3;

  logic          accept;
  logic          commit;
  logic [AW-1:0] wordIdx;
  logic          outOfRange;
  logic [3:0]    byteEn;
  logic [31:0]   wdataShift;
  logic [31:0]   loadData;
  logic          laneErr;
  logic          rspErrNext;
  logic [31:0]   rspDataNext;
  logic          storeEn;

  assign accept = bus.req_valid && (state == DM_IDLE);

  // Request fields are latched on accept so req_* may change during the wait.
  always_ff @(posedge clk) begin
    if (accept) begin
      weReg     <= bus.req_we;
      addrReg   <= bus.req_addr;
      wdataReg  <= bus.req_wdata;
      funct3Reg <= bus.req_funct3;
    end
  end

  // Zero wait states commit at the accept edge, so the live request is used.
  always_comb begin
    if (ZeroWait) begin
      effWe     = bus.req_we;
      effAddr   = bus.req_addr;
      effWdata  = bus.req_wdata;
      effFunct3 = bus.req_funct3;
    end else begin
      effWe     = weReg;
      effAddr   = addrReg;
      effWdata  = wdataReg;
      effFunct3 = funct3Reg;
    end
  end

  assign commit     = ZeroWait ? accept : ((state == DM_WAIT) && (waitCnt == '0));
  assign wordIdx    = effAddr[AW+1:2];
  assign outOfRange = |effAddr[31:AW+2];

  dmem_lane_align u_lane_align (
    .funct3     (effFunct3),
    .addrLo     (effAddr[1:0]),
    .we         (effWe),
    .wdata      (effWdata),
    .rawWord    (mem[wordIdx]),
    .byteEn     (byteEn),
    .wdataShift (wdataShift),
    .loadData   (loadData),
    .alignErr   (laneErr)
  );

  assign rspErrNext  = laneErr || outOfRange;
  assign rspDataNext = (rspErrNext || effWe) ? '0 : loadData;
  assign storeEn     = commit && effWe && !rspErrNext;

  always_ff @(posedge clk) begin
    if (storeEn) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wdataShift[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DM_IDLE;
      waitCnt  <= '0;
      rspValid <= 1'b0;
      rspRdata <= '0;
      rspErr   <= 1'b0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (accept) begin
            if (ZeroWait) begin
              state    <= DM_RESP;
              rspValid <= 1'b1;
              rspRdata <= rspDataNext;
              rspErr   <= rspErrNext;
            end else begin
              state   <= DM_WAIT;
              waitCnt <= WaitInit;
            end
          end
        end
        DM_WAIT: begin
          if (waitCnt == '0) begin
            state    <= DM_RESP;
            rspValid <= 1'b1;
            rspRdata <= rspDataNext;
            rspErr   <= rspErrNext;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        DM_RESP: begin
          if (bus.rsp_ready) begin
            state    <= DM_IDLE;
            rspValid <= 1'b0;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == DM_IDLE);
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspRdata;
  assign bus.rsp_err   = rspErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (2, 0 and 3 wait states) against a
// byte-array reference model, directed vectors plus randomized traffic.
module tb_dmem_responder;

  localparam int TB_DEPTH = 64;
  localparam int NDUT     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NDUT-1:0] reqValid, reqWe, rspReady;
  logic [NDUT-1:0] reqReady, rspValid, rspErr;
  logic [31:0]     reqAddr  [NDUT];
  logic [31:0]     reqWdata [NDUT];
  logic [2:0]      reqF3    [NDUT];
  logic [31:0]     rspRdata [NDUT];

  dmem_responder_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : gConn
    assign bus[g].req_valid  = reqValid[g];
    assign bus[g].req_we     = reqWe[g];
    assign bus[g].req_addr   = reqAddr[g];
    assign bus[g].req_wdata  = reqWdata[g];
    assign bus[g].req_funct3 = reqF3[g];
    assign bus[g].rsp_ready  = rspReady[g];
    assign reqReady[g]       = bus[g].req_ready;
    assign rspValid[g]       = bus[g].rsp_valid;
    assign rspRdata[g]       = bus[g].rsp_rdata;
    assign rspErr[g]         = bus[g].rsp_err;
  end

  dmem_responder #(.DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus[0]));
  dmem_responder #(.DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus[1]));
  dmem_responder #(.DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(3)) dut2 (.clk(clk), .rst(rst), .bus(bus[2]));

  int checks = 0;
  int errors = 0;
  int expLat [NDUT];
  logic [7:0] refBytes [NDUT][TB_DEPTH*4];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: a flat byte array; access size 1/2/4 from funct3[1:0].
  function automatic void refTxn(int d, bit we, logic [31:0] addr, logic [31:0] wdata,
                                 logic [2:0] f3, output logic [31:0] rd, output logic er);
    int size = 1 << f3[1:0];
    bit legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bit sgn = (f3 < 3'd4);
    longint unsigned val = 0;
    rd = '0;
    er = !legal || ((addr % size) != 0) || (addr >= TB_DEPTH * 4);
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) refBytes[d][addr + i] = 8'(wdata >> (8 * i));
    end else begin
      for (int i = 0; i < size; i++) val += longint'(refBytes[d][addr + i]) << (8 * i);
      if (sgn && size < 4 && val >= (longint'(1) << (8 * size - 1)))
        val += 64'hFFFF_FFFF - ((longint'(1) << (8 * size)) - 1);
      rd = 32'(val);
    end
  endfunction

  task automatic doTxn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input int hold, output logic [31:0] rd, output logic er);
    int lat;
    bit busyRdy;
    bit unstable;
    logic [31:0] heldRd;
    logic heldEr;
    for (int i = 0; i < 50 && !reqReady[d]; i++) @(negedge clk);
    check("req_ready before issue", reqReady[d], 1);
    reqValid[d] = 1'b1; reqWe[d] = we; reqAddr[d] = addr; reqWdata[d] = wdata; reqF3[d] = f3;
    rspReady[d] = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    reqValid[d] = 1'b0; reqWe[d] = 1'($urandom); reqAddr[d] = $urandom;
    reqWdata[d] = $urandom; reqF3[d] = 3'($urandom);
    lat = 1;
    busyRdy = 1'b0;
    while (!rspValid[d] && lat < 40) begin
      busyRdy |= reqReady[d];
      @(negedge clk);
      lat++;
    end
    busyRdy |= reqReady[d];
    check($sformatf("latency dut%0d", d), lat, expLat[d]);
    heldRd = rspRdata[d];
    heldEr = rspErr[d];
    unstable = 1'b0;
    // Backpressure: a second request (a word store) is offered and must be ignored.
    for (int h = 0; h < hold; h++) begin
      reqValid[d] = 1'b1; reqWe[d] = 1'b1; reqAddr[d] = addr; reqWdata[d] = ~wdata; reqF3[d] = 3'd2;
      @(negedge clk);
      unstable |= (!rspValid[d]) || (rspRdata[d] !== heldRd) || (rspErr[d] !== heldEr);
      busyRdy |= reqReady[d];
    end
    reqValid[d] = 1'b0;
    rspReady[d] = 1'b1;
    if (hold > 0) check("rsp stable under backpressure", unstable, 0);
    check("req_ready low while busy", busyRdy, 0);
    rd = heldRd;
    er = heldEr;
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid drops after handshake", rspValid[d], 0);
    check("req_ready back in idle", reqReady[d], 1);
  endtask

  task automatic runTxn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int hold, input string tag);
    logic [31:0] expRd, rd;
    logic expEr, er;
    refTxn(d, we, addr, wdata, f3, expRd, expEr);
    doTxn(d, we, addr, wdata, f3, hold, rd, er);
    check({tag, " rdata"}, rd, expRd);
    check({tag, " err"}, er, expEr);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          hold;
    logic [31:0] expRd;
    bit          expEr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, expRd;
    logic er, expEr;
    logic [31:0] addr;
    int hold;

    expLat[0] = 3; expLat[1] = 1; expLat[2] = 4;
    for (int d = 0; d < NDUT; d++) begin
      reqValid[d] = 1'b0; reqWe[d] = 1'b0; rspReady[d] = 1'b1;
      reqAddr[d] = '0; reqWdata[d] = '0; reqF3[d] = '0;
    end

    vecs.push_back('{1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 32'h0,        0});
    vecs.push_back('{0, 32'h10, 32'h0,        3'd2, 0, 32'hDEADBEEF, 0});
    vecs.push_back('{1, 32'h13, 32'h0000007F, 3'd0, 0, 32'h0,        0});
    vecs.push_back('{0, 32'h10, 32'h0,        3'd2, 0, 32'h7FADBEEF, 0});
    vecs.push_back('{0, 32'h12, 32'h0,        3'd0, 0, 32'hFFFFFFAD, 0});
    vecs.push_back('{0, 32'h12, 32'h0,        3'd4, 0, 32'h000000AD, 0});
    vecs.push_back('{1, 32'h20, 32'h00008001, 3'd1, 0, 32'h0,        0});
    vecs.push_back('{0, 32'h20, 32'h0,        3'd1, 0, 32'hFFFF8001, 0});
    vecs.push_back('{0, 32'h20, 32'h0,        3'd5, 0, 32'h00008001, 0});
    vecs.push_back('{0, 32'h11, 32'h0,        3'd2, 0, 32'h0,        1});
    vecs.push_back('{1, 32'h21, 32'h00001234, 3'd1, 0, 32'h0,        1});
    vecs.push_back('{0, 32'h20, 32'h0,        3'd3, 0, 32'h0,        1});
    vecs.push_back('{0, 32'h100, 32'h0,       3'd2, 0, 32'h0,        1});
    vecs.push_back('{1, 32'h100, 32'h55555555, 3'd2, 0, 32'h0,       1});
    vecs.push_back('{1, 32'h20, 32'hFFFFFFFF, 3'd3, 0, 32'h0,        1});
    vecs.push_back('{0, 32'h20, 32'h0,        3'd2, 0, 32'h00008001, 0});
    vecs.push_back('{0, 32'h22, 32'h0,        3'd1, 0, 32'h00000000, 0});
    vecs.push_back('{0, 32'h10, 32'h0,        3'd2, 5, 32'h7FADBEEF, 0});
    vecs.push_back('{0, 32'h10, 32'h0,        3'd2, 0, 32'h7FADBEEF, 0});

    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset rsp_valid dut%0d", d), rspValid[d], 0);
      check($sformatf("reset rsp_rdata dut%0d", d), rspRdata[d], 0);
      check($sformatf("reset rsp_err dut%0d", d), rspErr[d], 0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check($sformatf("reset req_ready dut%0d", d), reqReady[d], 1);

    // Zero-fill so every byte has a known value
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < TB_DEPTH; w++) runTxn(d, 1'b1, 32'(w * 4), 32'h0, 3'd2, 0, "init");

    // Directed vectors on the two-wait-state build
    foreach (vecs[i]) begin
      refTxn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, expRd, expEr);
      doTxn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].hold, rd, er);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].expRd);
      check($sformatf("vec%0d err", i), er, vecs[i].expEr);
    end

    // Zero-wait build: requests held valid are accepted every second cycle
    runTxn(1, 1'b1, 32'h10, 32'hCAFEF00D, 3'd2, 0, "w0 store");
    refTxn(1, 1'b0, 32'h10, 32'h0, 3'd2, expRd, expEr);
    reqValid[1] = 1'b1; reqWe[1] = 1'b0; reqAddr[1] = 32'h10; reqF3[1] = 3'd2; rspReady[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) reqValid[1] = 1'b0;
      check($sformatf("b2b rsp_valid k%0d", k), rspValid[1], (k % 2 == 0));
      check($sformatf("b2b req_ready k%0d", k), reqReady[1], (k % 2 == 1));
      if (k % 2 == 0) check($sformatf("b2b rdata k%0d", k), rspRdata[1], expRd);
    end
    @(negedge clk);

    // Reset in the middle of a three-wait-state store: the store is dropped
    runTxn(2, 1'b1, 32'h30, 32'h5, 3'd2, 0, "pre-reset store");
    runTxn(2, 1'b0, 32'h30, 32'h0, 3'd2, 0, "pre-reset load");
    reqValid[2] = 1'b1; reqWe[2] = 1'b1; reqAddr[2] = 32'h30; reqWdata[2] = 32'h1; reqF3[2] = 3'd2;
    @(posedge clk);
    @(negedge clk);
    reqValid[2] = 1'b0;
    check("req_ready in wait", reqReady[2], 0);
    rst = 1'b0;
    #1;
    check("mid-op reset rsp_valid", rspValid[2], 0);
    check("mid-op reset rsp_rdata", rspRdata[2], 0);
    check("mid-op reset rsp_err", rspErr[2], 0);
    check("mid-op reset req_ready", reqReady[2], 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    runTxn(2, 1'b0, 32'h30, 32'h0, 3'd2, 0, "post-reset load");

    // Randomized traffic against the model
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 120; n++) begin
        addr = 32'($urandom_range(0, TB_DEPTH * 4 + 31));
        if ($urandom_range(0, 15) == 0) addr |= 32'h1 << $urandom_range(8, 31);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        runTxn(d, 1'($urandom), addr, $urandom, 3'($urandom_range(0, 7)), hold,
               $sformatf("rand dut%0d n%0d", d, n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
